// File: rtl/acc_cpu.sv
// Single-cycle accumulator CPU: one instruction per enabled clock edge, with flags,
// an I/O port, and a return-address stack that sets a sticky error on misuse.
module acc_cpu #(
    parameter int WIDTH       = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] instr,
    input  logic [WIDTH-1:0] arg,
    input  logic [WIDTH-1:0] port_in,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] port_out,
    output logic             zf,
    output logic             cf,
    output logic             halted,
    output logic             stack_err
);

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0, OP_LDI = 4'h1, OP_ADD = 4'h2, OP_SUB  = 4'h3,
        OP_AND  = 4'h4, OP_OR  = 4'h5, OP_XOR = 4'h6, OP_IN   = 4'h7,
        OP_OUT  = 4'h8, OP_JMP = 4'h9, OP_JZ  = 4'hA, OP_JC   = 4'hB,
        OP_CALL = 4'hC, OP_RET = 4'hD, OP_HALT = 4'hE, OP_NOP2 = 4'hF
    } opcode_e;

    // Stack pointer counts occupied entries (0..STACK_DEPTH); the array is sized to
    // the pointer's range so indexing needs no width juggling.
    localparam int            SPW     = $clog2(STACK_DEPTH + 1);
    localparam int            SLOTS   = 1 << SPW;
    localparam logic [SPW-1:0] SP_FULL = SPW'(STACK_DEPTH);

    logic [WIDTH-1:0] pc_q, pc_d, acc_q, acc_d, pout_q, pout_d;
    logic             zf_q, zf_d, cf_q, cf_d, halted_q, halted_d, serr_q, serr_d;
    logic [SPW-1:0]   sp_q, sp_d, sp_m1_s;
    logic [WIDTH-1:0] stack_q [SLOTS];
    logic [WIDTH-1:0] stack_d [SLOTS];
    logic [WIDTH-1:0] pc_inc_s;
    logic [WIDTH:0]   sum_s, diff_s;
    opcode_e          op_s;
    logic [WIDTH-1:0] unused_instr_bits;

    assign unused_instr_bits = instr;
    assign op_s     = opcode_e'(instr[3:0]);
    assign pc_inc_s = pc_q + {{(WIDTH-1){1'b0}}, 1'b1};
    assign sp_m1_s  = sp_q - {{(SPW-1){1'b0}}, 1'b1};
    assign sum_s    = {1'b0, acc_q} + {1'b0, arg};
    assign diff_s   = {1'b0, acc_q} - {1'b0, arg};

    // Next-state decode of the current instruction
    always_comb begin
        pc_d     = pc_q;
        acc_d    = acc_q;
        pout_d   = pout_q;
        zf_d     = zf_q;
        cf_d     = cf_q;
        halted_d = halted_q;
        serr_d   = serr_q;
        sp_d     = sp_q;
        stack_d  = stack_q;
        if (en && !halted_q) begin
            pc_d = pc_inc_s;
            case (op_s)
                OP_LDI: begin acc_d = arg;                 zf_d = (arg == {WIDTH{1'b0}}); end
                OP_ADD: begin acc_d = sum_s[WIDTH-1:0];    cf_d = sum_s[WIDTH];
                              zf_d  = (sum_s[WIDTH-1:0] == {WIDTH{1'b0}}); end
                OP_SUB: begin acc_d = diff_s[WIDTH-1:0];   cf_d = diff_s[WIDTH];
                              zf_d  = (diff_s[WIDTH-1:0] == {WIDTH{1'b0}}); end
                OP_AND: begin acc_d = acc_q & arg;         zf_d = ((acc_q & arg) == {WIDTH{1'b0}}); end
                OP_OR:  begin acc_d = acc_q | arg;         zf_d = ((acc_q | arg) == {WIDTH{1'b0}}); end
                OP_XOR: begin acc_d = acc_q ^ arg;         zf_d = ((acc_q ^ arg) == {WIDTH{1'b0}}); end
                OP_IN:  begin acc_d = port_in;             zf_d = (port_in == {WIDTH{1'b0}}); end
                OP_OUT: pout_d = acc_q;
                OP_JMP: pc_d = arg;
                OP_JZ:  begin
                    if (zf_q) pc_d = arg;
                    else      pc_d = pc_inc_s;
                end
                OP_JC:  begin
                    if (cf_q) pc_d = arg;
                    else      pc_d = pc_inc_s;
                end
                OP_CALL: begin
                    pc_d = arg;
                    if (sp_q == SP_FULL) begin
                        serr_d = 1'b1;
                    end else begin
                        stack_d[sp_q] = pc_inc_s;
                        sp_d          = sp_q + {{(SPW-1){1'b0}}, 1'b1};
                    end
                end
                OP_RET: begin
                    if (sp_q == {SPW{1'b0}}) begin
                        serr_d = 1'b1;
                    end else begin
                        pc_d = stack_q[sp_m1_s];
                        sp_d = sp_m1_s;
                    end
                end
                OP_HALT: begin halted_d = 1'b1; pc_d = pc_q; end
                default: ;
            endcase
        end else begin
            pc_d = pc_q;
        end
    end

    // Architectural state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= {WIDTH{1'b0}};
            acc_q    <= {WIDTH{1'b0}};
            pout_q   <= {WIDTH{1'b0}};
            zf_q     <= 1'b0;
            cf_q     <= 1'b0;
            halted_q <= 1'b0;
            serr_q   <= 1'b0;
            sp_q     <= {SPW{1'b0}};
            for (int i = 0; i < SLOTS; i++) stack_q[i] <= {WIDTH{1'b0}};
        end else begin
            pc_q     <= pc_d;
            acc_q    <= acc_d;
            pout_q   <= pout_d;
            zf_q     <= zf_d;
            cf_q     <= cf_d;
            halted_q <= halted_d;
            serr_q   <= serr_d;
            sp_q     <= sp_d;
            stack_q  <= stack_d;
        end
    end

    assign pc        = pc_q;
    assign acc       = acc_q;
    assign port_out  = pout_q;
    assign zf        = zf_q;
    assign cf        = cf_q;
    assign halted    = halted_q;
    assign stack_err = serr_q;

endmodule

// File: tb/tb_acc_cpu.sv
// Scoreboard bench for acc_cpu (WIDTH=8, STACK_DEPTH=2): expected architectural state
// is queued as each instruction is driven and compared after the clock edge.
module tb_acc_cpu;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [7:0] instr = 8'h00, arg = 8'h00, port_in = 8'h00;
    logic [7:0] pc, acc, port_out;
    logic       zf, cf, halted, stack_err;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [7:0] pc, acc, pout;
        logic       zf, cf, halted, serr;
    } exp_t;
    exp_t sb_q[$];

    acc_cpu #(.WIDTH(8), .STACK_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .instr(instr), .arg(arg), .port_in(port_in),
        .pc(pc), .acc(acc), .port_out(port_out), .zf(zf), .cf(cf),
        .halted(halted), .stack_err(stack_err)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic compare_state(input string tag, input exp_t e);
        check({tag, ".pc"},   pc,        e.pc);
        check({tag, ".acc"},  acc,       e.acc);
        check({tag, ".pout"}, port_out,  e.pout);
        check({tag, ".zf"},   zf,        e.zf);
        check({tag, ".cf"},   cf,        e.cf);
        check({tag, ".halt"}, halted,    e.halted);
        check({tag, ".serr"}, stack_err, e.serr);
    endtask

    // Drive one instruction, queue its expected result, clock, then pop and compare.
    task automatic step(input string tag, input logic [3:0] op, input logic [7:0] a,
                        input logic e_en, input logic [7:0] epc, input logic [7:0] eacc,
                        input logic [7:0] epo, input logic ezf, input logic ecf,
                        input logic eh, input logic eerr);
        exp_t e;
        instr = {4'h0, op};
        arg   = a;
        en    = e_en;
        e = '{pc: epc, acc: eacc, pout: epo, zf: ezf, cf: ecf, halted: eh, serr: eerr};
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check({tag, ".sb_empty"}, 32'd1, 32'd0);
        end else begin
            compare_state(tag, sb_q.pop_front());
        end
    endtask

    initial begin
        exp_t zero_s;
        zero_s = '0;
        #2;
        compare_state("reset", zero_s);
        @(negedge clk);
        rst_n = 1'b1;

        // Arithmetic and flags
        step("ldi_f0", 4'h1, 8'hF0, 1'b1, 8'h01, 8'hF0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        step("add_20", 4'h2, 8'h20, 1'b1, 8'h02, 8'h10, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        step("sub_10", 4'h3, 8'h10, 1'b1, 8'h03, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        step("ldi_05", 4'h1, 8'h05, 1'b1, 8'h04, 8'h05, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        step("sub_06", 4'h3, 8'h06, 1'b1, 8'h05, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        step("jc_40",  4'hB, 8'h40, 1'b1, 8'h40, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        step("jz_80",  4'hA, 8'h80, 1'b1, 8'h41, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        step("jmp_ff", 4'h9, 8'hFF, 1'b1, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        step("nop_wr", 4'hF, 8'h12, 1'b1, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);

        // Stack: two nested calls fit, the third overflows but still jumps
        step("call10", 4'hC, 8'h10, 1'b1, 8'h10, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        step("call20", 4'hC, 8'h20, 1'b1, 8'h20, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        step("call30", 4'hC, 8'h30, 1'b1, 8'h30, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
        step("ret1",   4'hD, 8'h00, 1'b1, 8'h11, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
        step("ret2",   4'hD, 8'h00, 1'b1, 8'h01, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
        step("ret3",   4'hD, 8'h00, 1'b1, 8'h02, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);

        // Port I/O with an enable gap
        port_in = 8'hA5;
        step("in_a5",  4'h7, 8'h00, 1'b1, 8'h03, 8'hA5, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++)
            step("en_off", 4'h8, 8'h00, 1'b0, 8'h03, 8'hA5, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
        step("out",    4'h8, 8'h00, 1'b1, 8'h04, 8'hA5, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b1);
        step("xor_a5", 4'h6, 8'hA5, 1'b1, 8'h05, 8'h00, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b1);

        // Halt freezes everything, whatever is presented afterwards
        step("jmp_07", 4'h9, 8'h07, 1'b1, 8'h07, 8'h00, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b1);
        step("halt",   4'hE, 8'h00, 1'b1, 8'h07, 8'h00, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++)
            step("halted", 4'h1, 8'h55, i[0], 8'h07, 8'h00, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b1);

        // Asynchronous reset between edges, then restart from pc=0
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        compare_state("async_rst", zero_s);
        @(negedge clk);
        rst_n = 1'b1;
        step("restart", 4'h1, 8'h3C, 1'b1, 8'h01, 8'h3C, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        step("ret_emp", 4'hD, 8'h00, 1'b1, 8'h02, 8'h3C, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

        check("sb_drained", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
